gray_to_binary: RTL and testbench
=================================

Name: gray_to_binary

Overview:
- Converts a WIDTH-bit reflected Gray code word to its natural binary value.
- Optional pipelining gives a configurable, fixed latency with a valid flag aligned to the data.
- Sits after Gray-coded sources: CDC pointer synchronisers, rotary/absolute encoders, Gray counters.
- Feeds binary arithmetic such as FIFO level compare and position math.

Parameters:
- WIDTH, 4, bit width of the gray and binary words; legal range 2..64.
- PIPE_STAGES, 1, number of register stages in the conversion path; legal range 0..WIDTH; equals the latency in clk cycles.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- gray  input  WIDTH  Gray-coded input word.
- gray_valid  input  1  qualifies gray for the current cycle.
- binary  output  WIDTH  converted binary word.
- binary_valid  output  1  qualifies binary; it is gray_valid delayed by PIPE_STAGES cycles.
- step_err  output  1  Gray step-violation flag, aligned with binary_valid; tied 0 unless the optional feature is compiled in.

Behaviour:
- Conversion rule, MSB first:
  - binary[WIDTH-1] = gray[WIDTH-1].
  - binary[i] = binary[i+1] XOR gray[i], for i = WIDTH-2 down to 0.
  - Equivalently, binary[i] is the XOR of gray[WIDTH-1:i].
- Pipelining:
  - The XOR chain is split into PIPE_STAGES contiguous slices, MSB to LSB, of near-equal length.
  - Earlier slices hold at most one more bit than later ones.
  - Each stage registers the bits resolved so far, the running prefix XOR, the still-unconverted gray bits, and the valid bit.
- Latency:
  - PIPE_STAGES = N > 0: an input accepted at edge k appears at binary at edge k+N.
  - PIPE_STAGES = 0: fully combinational; binary and binary_valid follow the inputs in the same cycle, and rst_n has no effect.
- Throughput: one word per cycle. No backpressure and no ready signal.
- Data regs capture every cycle regardless of gray_valid. binary is meaningful only while binary_valid = 1.
- Reset, asserted asynchronously:
  - All pipeline registers, binary, binary_valid and step_err go to 0 immediately.
  - Deassertion is synchronised by the integrator upstream.
- Reset mid-operation: in-flight words are discarded. binary_valid stays 0 until the first post-reset input has traversed N stages.
- Boundary values:
  - all-zero maps to all-zero.
  - all-ones maps to alternating 1010... (MSB = 1).
  - 1000... (MSB only) maps to all-ones.
- Widths: no truncation or extension. Output width equals input width.

Optional Feature:
- Macro: GRAY_TO_BINARY_STEP_CHECK_EN.
- Defined:
  - Keeps a register of the last valid gray word plus a "have-previous" flag; both clear on reset.
  - On each valid input, computes the popcount of (gray XOR last).
  - If popcount > 1 and have-previous = 1, step_err = 1 for that word; popcount 0 (hold) or 1 (legal step) gives 0.
  - step_err is pipelined with the data and asserts only alongside binary_valid = 1.
  - The first valid word after reset never flags.
  - Invalid cycles do not update last.
- Undefined: step_err is tied to constant 0 and no extra registers exist.

Test Plan:
- Sweep, WIDTH=4, PIPE_STAGES=1: feed gray 0000..1111 on consecutive cycles with gray_valid=1. binary one cycle later must be 0000,0001,0011,0010,0111,0110,0100,0101,1111,1110,1100,1101,1000,1001,1011,1010, with binary_valid=1 on each.
- Latency: WIDTH=8, PIPE_STAGES=3, single valid pulse of gray=8'hFF -> binary=8'hAA with binary_valid exactly 3 cycles later, pulse width 1.
- Combinational: PIPE_STAGES=0, gray=4'b1000 -> binary=4'b1111 in the same cycle; binary_valid follows gray_valid.
- Async reset: with valid words in flight, pull rst_n low between edges -> binary=0, binary_valid=0 immediately; after release, no stale word emerges.
- Gaps: alternate gray_valid 1/0 with gray=0110 then 1011 -> binary_valid pattern mirrors input delayed by N; binary values 0100 then 1101.
- Step check, macro defined: valid sequence 0000, 0001, 0111 -> step_err = 0, 0, 1. A repeated 0111 -> step_err = 0. First word after reset with any value -> step_err = 0.

Source files
------------

// File: rtl/gray_to_binary.sv
// Reflected Gray to binary converter with a PIPE_STAGES-deep register pipeline and a valid flag.
// Optional Gray step-violation checker is compiled in with GRAY_TO_BINARY_STEP_CHECK_EN.
module gray_to_binary #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray,
    input  logic             gray_valid,
    output logic [WIDTH-1:0] binary,
    output logic             binary_valid,
    output logic             step_err
);
    localparam int unsigned NS   = (PIPE_STAGES == 0) ? 1 : PIPE_STAGES;
    localparam int unsigned BASE = WIDTH / NS;
    localparam int unsigned REM  = WIDTH % NS;
    localparam int unsigned IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Earlier slices take the remainder bits, so they are at most one bit longer than later ones.
    function automatic int unsigned slice_start(input int unsigned s);
        return s * BASE + ((s < REM) ? s : REM);
    endfunction

    function automatic int unsigned slice_len(input int unsigned s);
        return BASE + ((s < REM) ? 32'd1 : 32'd0);
    endfunction

    // Bits above the slice are already binary; the lowest of them is the running prefix XOR,
    // so the word register carries the prefix without a separate flop.
    function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH-1:0] w, input int unsigned s);
        logic [WIDTH-1:0] r;
        logic             acc;
        logic [IW-1:0]    idx;
        int unsigned      top;
        r   = w;
        top = WIDTH - slice_start(s);
        acc = 1'b0;
        if (top < WIDTH) begin
            idx = IW'(top);
            acc = w[idx];
        end
        for (int unsigned k = 0; k < slice_len(s); k++) begin
            idx    = IW'(top - 1 - k);
            acc    = acc ^ w[idx];
            r[idx] = acc;
        end
        return r;
    endfunction

`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
    logic [WIDTH-1:0] last;
    logic             have_prev;
    logic             err_in;

    always_comb begin
        err_in = gray_valid && have_prev && ($countones(gray ^ last) > 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= '0;
            have_prev <= 1'b0;
        end else if (gray_valid) begin
            last      <= gray;
            have_prev <= 1'b1;
        end
    end
`else
    assign step_err = 1'b0;
`endif

    if (PIPE_STAGES == 0) begin : g_comb
        always_comb begin
            binary       = resolve(gray, 32'd0);
            binary_valid = gray_valid;
`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
            step_err     = err_in;
`endif
        end
    end else begin : g_pipe
        logic [WIDTH-1:0] word_q  [PIPE_STAGES];
        logic             valid_q [PIPE_STAGES];
`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
        logic             err_q   [PIPE_STAGES];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned s = 0; s < PIPE_STAGES; s++) err_q[s] <= 1'b0;
            end else begin
                err_q[0] <= err_in;
                for (int unsigned s = 1; s < PIPE_STAGES; s++) err_q[s] <= err_q[s-1];
            end
        end

        always_comb begin
            step_err = err_q[PIPE_STAGES-1];
        end
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
                    word_q[s]  <= '0;
                    valid_q[s] <= 1'b0;
                end
            end else begin
                word_q[0]  <= resolve(gray, 32'd0);
                valid_q[0] <= gray_valid;
                for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
                    word_q[s]  <= resolve(word_q[s-1], s);
                    valid_q[s] <= valid_q[s-1];
                end
            end
        end

        always_comb begin
            binary       = word_q[PIPE_STAGES-1];
            binary_valid = valid_q[PIPE_STAGES-1];
        end
    end
endmodule

// File: tb/tb_gray_to_binary.sv
// Scoreboard bench for gray_to_binary: three instances (W4/P1, W8/P3, W4/P0) share one stimulus stream.
// Expected words come from a prefix-XOR-by-shifts model and are checked for value, latency and step_err.
module tb_gray_to_binary;
    typedef struct {
        logic [63:0] bin;
        logic        err;
        int unsigned due;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       gv    = 1'b0;
    logic [3:0] g4    = '0;
    logic [7:0] g8    = '0;
    logic [3:0] bin_a, bin_c;
    logic [7:0] bin_b;
    logic       v_a, v_b, v_c, e_a, e_b, e_c;

    int unsigned cyc    = 0;
    int unsigned checks = 0;
    int unsigned passed = 0;
    exp_t qa[$], qb[$], qc[$];
`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
    logic [63:0] last_m [3];
    logic        have_m [3];
`endif

    gray_to_binary #(.WIDTH(4), .PIPE_STAGES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .gray(g4), .gray_valid(gv),
        .binary(bin_a), .binary_valid(v_a), .step_err(e_a));
    gray_to_binary #(.WIDTH(8), .PIPE_STAGES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .gray(g8), .gray_valid(gv),
        .binary(bin_b), .binary_valid(v_b), .step_err(e_b));
    gray_to_binary #(.WIDTH(4), .PIPE_STAGES(0)) u_c (
        .clk(clk), .rst_n(rst_n), .gray(g4), .gray_valid(gv),
        .binary(bin_c), .binary_valid(v_c), .step_err(e_c));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned idx, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at cycle %0d", name, idx, got, exp, cyc);
    endtask

    // binary = g ^ g>>1 ^ g>>2 ^ ... restricted to w bits
    function automatic logic [63:0] g2b(input logic [63:0] g, input int unsigned w);
        logic [63:0] m, b;
        m = (64'd1 << w) - 64'd1;
        b = '0;
        for (int unsigned k = 0; k < w; k++) b = b ^ ((g & m) >> k);
        return b;
    endfunction

    task automatic model_reset();
`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            last_m[i] = '0;
            have_m[i] = 1'b0;
        end
`endif
    endtask

    task automatic push(input int unsigned idx, input logic [63:0] g, input int unsigned w, input int unsigned lat);
        exp_t x;
        x.bin = g2b(g, w);
        x.due = cyc + lat;
        x.err = 1'b0;
`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
        begin
            logic [63:0] d;
            d = g ^ last_m[idx];
            x.err = have_m[idx] && ((d & (d - 64'd1)) != 64'd0);
            last_m[idx] = g;
            have_m[idx] = 1'b1;
        end
`endif
        case (idx)
            0:       qa.push_back(x);
            1:       qb.push_back(x);
            default: qc.push_back(x);
        endcase
    endtask

    task automatic issue(input logic [63:0] g, input logic v);
        @(posedge clk);
        #1;
        g4 = g[3:0];
        g8 = g[7:0];
        gv = v;
        if (v) begin
            push(0, {60'd0, g[3:0]}, 4, 1);
            push(1, {56'd0, g[7:0]}, 8, 3);
            push(2, {60'd0, g[3:0]}, 4, 0);
        end
    endtask

    task automatic observe(input int unsigned idx, input logic [63:0] b, input logic v, input logic e);
        exp_t        x;
        int unsigned n;
        if (!v) begin
            chk("err_while_idle", idx, 64'(e), 64'd0);
            return;
        end
        n = (idx == 0) ? qa.size() : (idx == 1) ? qb.size() : qc.size();
        if (n == 0) begin
            checks++;
            $display("FAIL stray_valid dut%0d: got valid=1 binary=%0h expected no word at cycle %0d", idx, b, cyc);
            return;
        end
        case (idx)
            0:       x = qa.pop_front();
            1:       x = qb.pop_front();
            default: x = qc.pop_front();
        endcase
        chk("binary", idx, b, x.bin);
        chk("latency", idx, 64'(cyc), 64'(x.due));
        chk("step_err", idx, 64'(e), 64'(x.err));
    endtask

    always @(negedge clk) begin
        observe(0, 64'(bin_a), v_a, e_a);
        observe(1, 64'(bin_b), v_b, e_b);
        observe(2, 64'(bin_c), v_c, e_c);
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_binary"}, 0, 64'(bin_a), 64'd0);
        chk({tag, "_valid"},  0, 64'(v_a),   64'd0);
        chk({tag, "_err"},    0, 64'(e_a),   64'd0);
        chk({tag, "_binary"}, 1, 64'(bin_b), 64'd0);
        chk({tag, "_valid"},  1, 64'(v_b),   64'd0);
        chk({tag, "_err"},    1, 64'(e_b),   64'd0);
    endtask

    // Assert reset between edges while words are in flight; nothing already issued may emerge.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        gv    = 1'b0;
        qa.delete();
        qb.delete();
        qc.delete();
        model_reset();
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) issue(64'(i), 1'b1);
        repeat (4) issue(64'd0, 1'b0);

        issue(64'hFF, 1'b1);
        repeat (5) issue(64'hFF, 1'b0);

        issue(64'h6, 1'b1);
        issue(64'h6, 1'b0);
        issue(64'hB, 1'b1);
        issue(64'hB, 1'b0);
        repeat (3) issue(64'd0, 1'b0);

        issue(64'h00, 1'b1);
        issue(64'hFF, 1'b1);
        issue(64'h08, 1'b1);
        issue(64'h80, 1'b1);

        repeat (300) issue({$urandom(), $urandom()}, ($urandom_range(3) != 0));

        issue(64'h5A, 1'b1);
        issue(64'hC3, 1'b1);
        issue(64'h96, 1'b1);
        issue(64'h3C, 1'b1);
        mid_reset();
        repeat (5) issue(64'hE7, 1'b0);

        issue(64'h0, 1'b1);
        issue(64'h1, 1'b1);
        issue(64'h7, 1'b1);
        issue(64'h7, 1'b1);

        repeat (100) issue({$urandom(), $urandom()}, ($urandom_range(3) != 0));
        repeat (6) issue(64'd0, 1'b0);

        chk("drain", 0, 64'(qa.size()), 64'd0);
        chk("drain", 1, 64'(qb.size()), 64'd0);
        chk("drain", 2, 64'(qc.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
